// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer
// Purpose  : Circular buffer of pending register-file writes sitting between
//            the execute stage and the register file. Stores are queued as
//            {addr[4:0], data[15:0]} and drained one per cycle in order.
//            Stores aimed at register 0 or outside the 32-entry register
//            space are discarded and flagged on drop. Writes that retire to
//            register 31 are mirrored on out_port.
// Options  : WB_FORWARD_EN - when defined, fwd_addr is looked up against the
//            queued entries and the newest match is returned on fwd_data.
//            When undefined, fwd_hit/fwd_data are tied to 0.
// Ports    : clk, rst (sync, active-low)
//            st_valid/st_ready/st_addr/st_data  - store request in
//            wr_en/wr_ready/wr_addr/wr_data     - register-file write out
//            fwd_addr/fwd_hit/fwd_data          - forwarding lookup
//            count     - number of queued entries
//            out_port  - last value committed to register 31
//            drop      - one-cycle pulse after a discarded store
// Revision : 1.0 - initial release
// ============================================================================
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        st_valid,
    output logic             st_ready,
    input  wire logic [11:0] st_addr,
    input  wire logic [15:0] st_data,
    output logic             wr_en,
    input  wire logic        wr_ready,
    output logic [4:0]       wr_addr,
    output logic [15:0]      wr_data,
    input  wire logic [11:0] fwd_addr,
    output logic             fwd_hit,
    output logic [15:0]      fwd_data,
    output logic [3:0]       count,
    output logic [15:0]      out_port,
    output logic             drop
);

    localparam int         PTR_W       = $clog2(DEPTH);
    localparam logic [3:0] c_DEPTH_CNT = 4'(DEPTH);

    // Entry storage carries no reset; validity is implied by the pointers.
    logic [4:0]       r_addr_mem [DEPTH];
    logic [15:0]      r_data_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_count;
    logic             r_drop;
    logic [15:0]      r_out_port;

    logic             w_accept;
    logic             w_addr_ok;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on occupancy so no combinational path exists from
    // wr_ready back to st_ready; a full buffer refuses even if a pop occurs.
    assign st_ready  = (r_count < c_DEPTH_CNT);
    assign w_accept  = st_valid && st_ready;
    assign w_addr_ok = (st_addr[11:5] == 7'd0) && (st_addr[4:0] != 5'd0);
    assign w_push    = w_accept && w_addr_ok;

    assign wr_en     = (r_count != 4'd0);
    assign wr_addr   = r_addr_mem[r_rd_ptr];
    assign wr_data   = r_data_mem[r_rd_ptr];
    assign w_pop     = wr_en && wr_ready;

    assign count     = r_count;
    assign drop      = r_drop;
    assign out_port  = r_out_port;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 4'd0;
            r_drop     <= 1'b0;
            r_out_port <= 16'd0;
        end else begin
            r_drop <= w_accept && !w_addr_ok;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (wr_addr == 5'd31) begin
                    r_out_port <= wr_data;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_addr_mem[r_wr_ptr] <= st_addr[4:0];
            r_data_mem[r_wr_ptr] <= st_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] w_fwd_idx;
    logic             w_fwd_hit;
    logic [15:0]      w_fwd_data;

    // Walk entries oldest to newest so a later match overrides an earlier
    // one. Only stored entries are searched; the store being accepted this
    // cycle is not yet visible.
    always_comb begin
        w_fwd_idx  = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = 16'd0;
        if ((fwd_addr[11:5] == 7'd0) && (fwd_addr[4:0] != 5'd0)) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_fwd_idx = r_rd_ptr + PTR_W'(k);
                if ((4'(k) < r_count) && (r_addr_mem[w_fwd_idx] == fwd_addr[4:0])) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_data_mem[w_fwd_idx];
                end
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^fwd_addr;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_buffer
// Purpose  : Directed self-checking bench for writeback_buffer (DEPTH = 4).
//            Inputs change and outputs are sampled 1 time unit after the
//            rising clock edge. Forwarding expectations follow WB_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_buffer;

`ifdef WB_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [11:0] st_addr;
    logic [15:0] st_data;
    logic        wr_en;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [11:0] fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [3:0]  count;
    logic [15:0] out_port;
    logic        drop;

    int n_checks = 0;
    int n_errors = 0;

    writeback_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count),
        .out_port (out_port),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic v, input logic [11:0] a, input logic [15:0] d);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        rst      = 1'b0;
        wr_ready = 1'b0;
        fwd_addr = 12'd0;
        set_store(1'b0, 12'd0, 16'd0);
        tick();
        tick();

        // Reset state
        check("rst_count",    32'(count),    32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_drop",     32'(drop),     32'd0);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_fwd_hit",  32'(fwd_hit),  32'd0);
        check("rst_fwd_data", 32'(fwd_data), 32'd0);
        rst = 1'b1;
        tick();

        // Single write, one cycle latency, popped the following cycle
        wr_ready = 1'b1;
        set_store(1'b1, 12'd5, 16'h1234);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("single_wr_en",   32'(wr_en),   32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd5);
        check("single_wr_data", 32'(wr_data), 32'h1234);
        check("single_count1",  32'(count),   32'd1);
        tick();
        check("single_count0",  32'(count),   32'd0);
        check("single_wr_en0",  32'(wr_en),   32'd0);

        // Fill to full with the register file stalled
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 12'(10 + i), 16'(16'h0100 + i));
            tick();
        end
        set_store(1'b1, 12'd20, 16'h9999);
        check("full_count",    32'(count),    32'd4);
        check("full_st_ready", 32'(st_ready), 32'd0);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("full_refused_count", 32'(count),   32'd4);
        check("full_hold_addr",     32'(wr_addr), 32'd10);
        check("full_hold_data",     32'(wr_data), 32'h0100);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_wr_en",   32'(wr_en),   32'd1);
            check("drain_wr_addr", 32'(wr_addr), 32'(10 + i));
            check("drain_wr_data", 32'(wr_data), 32'(16'h0100 + i));
            tick();
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_wr_en0", 32'(wr_en), 32'd0);

        // Simultaneous enqueue and pop keeps count steady
        wr_ready = 1'b0;
        set_store(1'b1, 12'd3, 16'h00A3);
        tick();
        wr_ready = 1'b1;
        set_store(1'b1, 12'd4, 16'h00A4);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("simul_count",   32'(count),   32'd1);
        check("simul_wr_addr", 32'(wr_addr), 32'd4);
        check("simul_wr_data", 32'(wr_data), 32'h00A4);
        tick();
        check("simul_drained", 32'(count), 32'd0);

        // Illegal destinations are dropped
        set_store(1'b1, 12'd0, 16'hAAAA);
        tick();
        set_store(1'b1, 12'h040, 16'hBBBB);
        check("drop0_pulse", 32'(drop),  32'd1);
        check("drop0_count", 32'(count), 32'd0);
        check("drop0_wr_en", 32'(wr_en), 32'd0);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("drop1_pulse", 32'(drop),  32'd1);
        check("drop1_count", 32'(count), 32'd0);
        check("drop1_wr_en", 32'(wr_en), 32'd0);
        tick();
        check("drop_clear",  32'(drop),  32'd0);
        check("drop_wr_en2", 32'(wr_en), 32'd0);

        // Forwarding picks the newest matching entry
        wr_ready = 1'b0;
        set_store(1'b1, 12'd7, 16'h0001);
        tick();
        set_store(1'b1, 12'd7, 16'h0002);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        fwd_addr = 12'd7;
        #1;
        check("fwd7_hit",  32'(fwd_hit),  c_FWD ? 32'd1 : 32'd0);
        check("fwd7_data", 32'(fwd_data), c_FWD ? 32'h0002 : 32'd0);
        fwd_addr = 12'd8;
        #1;
        check("fwd8_hit",  32'(fwd_hit),  32'd0);
        check("fwd8_data", 32'(fwd_data), 32'd0);
        fwd_addr = 12'h207;
        #1;
        check("fwd_hi_hit", 32'(fwd_hit), 32'd0);
        // A store presented in the same cycle is not forwarded
        fwd_addr = 12'd9;
        set_store(1'b1, 12'd9, 16'h0009);
        #1;
        check("fwd_same_cycle_hit", 32'(fwd_hit), 32'd0);
        set_store(1'b0, 12'd0, 16'd0);
        fwd_addr = 12'd0;
        wr_ready = 1'b1;
        tick();
        tick();
        check("fwd_drained", 32'(count), 32'd0);

        // Register 31 commit reaches out_port the cycle after pop
        set_store(1'b1, 12'd31, 16'hBEEF);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("r31_before_pop", 32'(out_port), 32'd0);
        check("r31_wr_en",      32'(wr_en),    32'd1);
        tick();
        check("r31_out_port",   32'(out_port), 32'hBEEF);

        // Reset mid-operation discards entries
        wr_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_store(1'b1, 12'(i), 16'(16'h0011 * i));
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd3);
        rst      = 1'b0;
        wr_ready = 1'b1;
        set_store(1'b1, 12'd0, 16'hDEAD);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("mid_rst_count",    32'(count),    32'd0);
        check("mid_rst_wr_en",    32'(wr_en),    32'd0);
        check("mid_rst_out_port", 32'(out_port), 32'd0);
        check("mid_rst_st_ready", 32'(st_ready), 32'd1);
        check("mid_rst_drop",     32'(drop),     32'd0);
        rst      = 1'b1;
        wr_ready = 1'b0;
        set_store(1'b1, 12'd6, 16'h0066);
        tick();
        set_store(1'b0, 12'd0, 16'd0);
        check("post_rst_count",   32'(count),   32'd1);
        check("post_rst_wr_addr", 32'(wr_addr), 32'd6);
        check("post_rst_wr_data", 32'(wr_data), 32'h0066);
        wr_ready = 1'b1;
        tick();
        check("post_rst_drained", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
